// File: rtl/alu_result_collector_if.sv
// Bundles the ALU-side sample bus and the consumer-side result handshake
// for the ALU result collector.
interface alu_result_collector_if #(
    parameter int ALU_WIDTH = 16
);
    logic [ALU_WIDTH-1:0] Arith_OUT;
    logic                 Carry_OUT;
    logic [ALU_WIDTH-1:0] Logic_OUT;
    logic [ALU_WIDTH-1:0] CMP_OUT;
    logic [ALU_WIDTH-1:0] SHIFT_OUT;
    logic                 Arith_Flag;
    logic                 Logic_Flag;
    logic                 CMP_Flag;
    logic                 SHIFT_Flag;
    logic                 in_valid;
    logic                 in_ready;
    logic [ALU_WIDTH-1:0] res_data;
    logic                 res_carry;
    logic [1:0]           res_unit;
    logic                 res_valid;
    logic                 res_ready;

    modport slave (
        input  Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
        input  Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
        input  in_valid, res_ready,
        output in_ready, res_data, res_carry, res_unit, res_valid
    );

    modport master (
        output Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
        output Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag,
        output in_valid, res_ready,
        input  in_ready, res_data, res_carry, res_unit, res_valid
    );
endinterface

// File: rtl/alu_result_collector.sv
// Collects one-hot-flagged ALU unit results into a small FWFT queue with a
// valid/ready consumer side; counts and drops samples with illegal flags.
module alu_result_collector #(
    parameter int ALU_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int ERR_W     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    alu_result_collector_if.slave    bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ERR_W-1:0]         err_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ALU_WIDTH-1:0] mem_data  [DEPTH];
    logic                 mem_carry [DEPTH];
    logic [1:0]           mem_unit  [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    logic [3:0]           flags;
    logic                 one_hot;
    logic [ALU_WIDTH-1:0] sel_data;
    logic                 sel_carry;
    logic [1:0]           sel_unit;
    logic                 full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 err_inc;

    assign flags   = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.SHIFT_Flag};
    assign one_hot = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);

    // Only consulted when one_hot is set, so the default branch is the arith unit.
    always_comb begin
        sel_data  = bus.Arith_OUT;
        sel_carry = bus.Carry_OUT;
        sel_unit  = 2'd0;
        unique case (flags)
            4'b0100: begin
                sel_data  = bus.Logic_OUT;
                sel_carry = 1'b0;
                sel_unit  = 2'd1;
            end
            4'b0010: begin
                sel_data  = bus.CMP_OUT;
                sel_carry = 1'b0;
                sel_unit  = 2'd2;
            end
            4'b0001: begin
                sel_data  = bus.SHIFT_OUT;
                sel_carry = 1'b0;
                sel_unit  = 2'd3;
            end
            default: ;
        endcase
    end

    assign full          = (count == CNT_W'(DEPTH));
    assign bus.in_ready  = !RST && !full;
    assign bus.res_valid = (count != '0);
    assign bus.res_data  = mem_data[rd_ptr];
    assign bus.res_carry = mem_carry[rd_ptr];
    assign bus.res_unit  = mem_unit[rd_ptr];

    assign accept  = bus.in_valid && bus.in_ready;
    assign push    = accept && one_hot;
    assign err_inc = accept && !one_hot;
    assign pop     = bus.res_valid && bus.res_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_carry[i] <= 1'b0;
                mem_unit[i]  <= 2'd0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= sel_data;
                mem_carry[wr_ptr] <= sel_carry;
                mem_unit[wr_ptr]  <= sel_unit;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: a cycle model predicts occupancy,
// handshake and error count; expected entries are queued on accept and popped on consume.
module tb_alu_result_collector;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic [1:0]  u;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    logic [7:0] err_cnt;

    int   n_cmp = 0;
    int   n_mis = 0;
    ent_t q[$];
    int   m_err = 0;
    bit   was_rst = 1'b0;

    alu_result_collector_if #(.ALU_WIDTH(16)) bus ();

    alu_result_collector #(.ALU_WIDTH(16), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .CLK     (clk),
        .RST     (rst),
        .bus     (bus),
        .count   (count),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] f, input logic [15:0] d, input logic c);
        bus.in_valid   = 1'b1;
        bus.Arith_Flag = f[3];
        bus.Logic_Flag = f[2];
        bus.CMP_Flag   = f[1];
        bus.SHIFT_Flag = f[0];
        bus.Arith_OUT  = f[3] ? d : 16'hDEAD;
        bus.Logic_OUT  = f[2] ? d : 16'hBEEF;
        bus.CMP_OUT    = f[1] ? d : 16'hCAFE;
        bus.SHIFT_OUT  = f[0] ? d : 16'hF00D;
        bus.Carry_OUT  = f[3] ? c : 1'b1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.Arith_Flag = 1'b0;
        bus.Logic_Flag = 1'b0;
        bus.CMP_Flag   = 1'b0;
        bus.SHIFT_Flag = 1'b0;
    endtask

    // Reference model: check current state, then predict the next edge.
    always @(negedge clk) begin : monitor
        logic [3:0] f;
        ent_t       e;
        bit         acc;
        bit         pp;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && q.size() < DEPTH)});
        check("res_valid", {31'd0, bus.res_valid}, {31'd0, (q.size() != 0)});
        check("count", {29'd0, count}, q.size());
        check("err_cnt", {24'd0, err_cnt}, m_err);
        if (q.size() != 0) begin
            check("res_data", {16'd0, bus.res_data}, {16'd0, q[0].d});
            check("res_carry", {31'd0, bus.res_carry}, {31'd0, q[0].c});
            check("res_unit", {30'd0, bus.res_unit}, {30'd0, q[0].u});
        end else if (was_rst) begin
            check("rst_res_data", {16'd0, bus.res_data}, 32'd0);
            check("rst_res_carry", {31'd0, bus.res_carry}, 32'd0);
            check("rst_res_unit", {30'd0, bus.res_unit}, 32'd0);
        end
        was_rst = rst;
        if (rst) begin
            q.delete();
            m_err = 0;
        end else begin
            f   = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.SHIFT_Flag};
            acc = bus.in_valid && (q.size() < DEPTH);
            pp  = (q.size() != 0) && bus.res_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                case (f)
                    4'b1000: begin e.d = bus.Arith_OUT; e.c = bus.Carry_OUT; e.u = 2'd0; q.push_back(e); end
                    4'b0100: begin e.d = bus.Logic_OUT; e.c = 1'b0; e.u = 2'd1; q.push_back(e); end
                    4'b0010: begin e.d = bus.CMP_OUT;   e.c = 1'b0; e.u = 2'd2; q.push_back(e); end
                    4'b0001: begin e.d = bus.SHIFT_OUT; e.c = 1'b0; e.u = 2'd3; q.push_back(e); end
                    default: if (m_err != 255) m_err++;
                endcase
            end
        end
    end

    initial begin
        bus.res_ready = 1'b0;
        bus.Arith_OUT = '0;
        bus.Logic_OUT = '0;
        bus.CMP_OUT   = '0;
        bus.SHIFT_OUT = '0;
        bus.Carry_OUT = 1'b0;
        idle();
        repeat (2) step();
        rst = 1'b0;

        // Two arith results with carry 0 then 1, consumer always ready.
        bus.res_ready = 1'b1;
        put(4'b1000, 16'd15, 1'b0); step();
        put(4'b1000, 16'd14, 1'b1); step();
        idle(); repeat (3) step();

        // Fill to DEPTH with one of each unit; fifth sample must be dropped.
        bus.res_ready = 1'b0;
        put(4'b0100, 16'h0001, 1'b0); step();
        put(4'b0010, 16'd2, 1'b0);    step();
        put(4'b0001, 16'h0012, 1'b0); step();
        put(4'b1000, 16'd50, 1'b1);   step();
        put(4'b0001, 16'd99, 1'b0);   step();
        put(4'b0000, 16'd0, 1'b0);    step();
        idle();
        @(negedge clk);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_err_unchanged", {24'd0, err_cnt}, 32'd0);

        // Drain two, then two illegal-flag samples.
        step(); bus.res_ready = 1'b1;
        step(); step(); bus.res_ready = 1'b0;
        put(4'b0000, 16'd3, 1'b0); step();
        put(4'b1100, 16'd4, 1'b0); step();
        idle();
        @(negedge clk);
        check("illegal_err", {24'd0, err_cnt}, 32'd2);
        check("illegal_count", {29'd0, count}, 32'd2);
        check("illegal_res_valid", {31'd0, bus.res_valid}, 32'd1);

        // Refill, then pop and offer a sample in the same full cycle.
        step();
        put(4'b0010, 16'd7, 1'b0); step();
        put(4'b1000, 16'd8, 1'b1); step();
        bus.res_ready = 1'b1;
        put(4'b0100, 16'd9, 1'b0); step();
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("full_pop_count", {29'd0, count}, 32'd3);
        step(); idle();
        @(negedge clk);
        check("retry_push_count", {29'd0, count}, 32'd4);

        // Drain, then saturate the error counter.
        step(); bus.res_ready = 1'b1;
        repeat (5) step();
        for (int i = 0; i < 260; i++) begin
            put(4'b1100, 16'(i), 1'b0); step();
        end
        idle();
        @(negedge clk);
        check("err_saturated", {24'd0, err_cnt}, 32'd255);

        // Reset with three entries queued.
        step(); bus.res_ready = 1'b0;
        put(4'b0001, 16'd21, 1'b0); step();
        put(4'b0010, 16'd22, 1'b0); step();
        put(4'b1000, 16'd23, 1'b1); step();
        idle(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_err", {24'd0, err_cnt}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        step();
        put(4'b0001, 16'h0055, 1'b0); step();
        idle();
        @(negedge clk);
        check("post_rst_data", {16'd0, bus.res_data}, 32'h55);
        check("post_rst_unit", {30'd0, bus.res_unit}, 32'd3);

        step(); bus.res_ready = 1'b1;
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
